// File: rtl/am_offset_ctrl.sv
// DC-offset estimation sequencer for am_offset: block-averages valid samples,
// acquires with the raw block mean, then tracks with a first-order update.
module am_offset_ctrl #(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned LOG2_WIN      = 10,
  parameter int unsigned SETTLE_BLOCKS = 4,
  parameter int unsigned STEP_SHIFT    = 2
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic [DATA_W-1:0] iS_data,
  input  logic              i_valid,
  input  logic              i_enable,
  input  logic              i_freeze,
  input  logic              i_manual,
  input  logic [DATA_W-1:0] iS_manual_offset,
  output logic [DATA_W-1:0] oS_offset,
  output logic              o_offset_load,
  output logic              o_locked
);

  localparam int unsigned ACC_W = DATA_W + LOG2_WIN;
  localparam int unsigned BLK_W = $clog2(SETTLE_BLOCKS + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [LOG2_WIN-1:0]      cnt_q, cnt_d;
  logic [BLK_W-1:0]         blk_q, blk_d;
  logic signed [DATA_W-1:0] mean_q, mean_d;
  logic signed [DATA_W-1:0] offset_q, offset_d;
  logic                     pend_q, pend_d;
  logic                     pend_acq_q, pend_acq_d;
  logic                     load_q, load_d;
  logic                     locked_q, locked_d;

  logic signed [ACC_W-1:0]  acc_sum;
  logic [BLK_W-1:0]         blk_inc;
  logic signed [DATA_W:0]   off_ext;
  logic signed [DATA_W:0]   diff;
  logic signed [DATA_W:0]   step;

  // Full-width block sum; its top DATA_W bits are the floor mean of the block.
  assign acc_sum = acc_q + {{LOG2_WIN{iS_data[DATA_W-1]}}, iS_data};
  assign blk_inc = blk_q + BLK_W'(1);
  assign off_ext = {offset_q[DATA_W-1], offset_q};
  assign diff    = {mean_q[DATA_W-1], mean_q} - off_ext;
  assign step    = diff >>> STEP_SHIFT;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      blk_q      <= '0;
      mean_q     <= '0;
      offset_q   <= '0;
      pend_q     <= 1'b0;
      pend_acq_q <= 1'b0;
      load_q     <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      blk_q      <= blk_d;
      mean_q     <= mean_d;
      offset_q   <= offset_d;
      pend_q     <= pend_d;
      pend_acq_q <= pend_acq_d;
      load_q     <= load_d;
      locked_q   <= locked_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    blk_d      = blk_q;
    mean_d     = mean_q;
    offset_d   = offset_q;
    pend_d     = 1'b0;
    pend_acq_d = pend_acq_q;
    load_d     = 1'b0;
    locked_d   = locked_q;

    // Apply the block mean registered on the previous edge.
    if (pend_q) begin
      load_d = 1'b1;
      if (pend_acq_q) begin
        offset_d = mean_q;
        blk_d    = blk_inc;
        if (blk_inc == BLK_W'(SETTLE_BLOCKS)) begin
          locked_d = 1'b1;
          if (state_q == ST_ACQUIRE) state_d = ST_TRACK;
        end
      end else begin
        offset_d = DATA_W'(off_ext + step);
      end
    end

    if (!i_enable) begin
      state_d  = ST_IDLE;
      acc_d    = '0;
      cnt_d    = '0;
      blk_d    = '0;
      offset_d = offset_q;
      load_d   = 1'b0;
      locked_d = 1'b0;
    end else if (i_manual) begin
      // Manual value wins over any pending block result.
      state_d  = (state_q == ST_IDLE) ? ST_ACQUIRE : ST_HOLD;
      acc_d    = '0;
      cnt_d    = '0;
      blk_d    = blk_q;
      offset_d = iS_manual_offset;
      load_d   = 1'b1;
      locked_d = locked_q;
    end else if (i_freeze) begin
      state_d = (state_q == ST_IDLE) ? ST_ACQUIRE : ST_HOLD;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_ACQUIRE;
        ST_HOLD: state_d = locked_d ? ST_TRACK : ST_ACQUIRE;
        default: begin
          if (i_valid) begin
            if (cnt_q == '1) begin
              mean_d     = acc_sum[ACC_W-1:LOG2_WIN];
              acc_d      = '0;
              cnt_d      = '0;
              pend_d     = 1'b1;
              pend_acq_d = (state_q == ST_ACQUIRE);
            end else begin
              acc_d = acc_sum;
              cnt_d = cnt_q + LOG2_WIN'(1);
            end
          end
        end
      endcase
    end
  end

  assign oS_offset     = offset_q;
  assign o_offset_load = load_q;
  assign o_locked      = locked_q;

endmodule

// File: tb/tb_am_offset_ctrl.sv
// Bench for am_offset_ctrl: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based block-averaging reference model.
module tb_am_offset_ctrl;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned L      = 4;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned SSHIFT = 2;
  localparam int          WIN    = 16;
  localparam int          GAIN   = 4;

  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_HOLD = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] iS_data;
  logic              i_valid;
  logic              i_enable;
  logic              i_freeze;
  logic              i_manual;
  logic [DATA_W-1:0] iS_manual_offset;
  logic [DATA_W-1:0] oS_offset;
  logic              o_offset_load;
  logic              o_locked;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int     m_phase;
  longint m_q[$];
  int     m_pend;
  int     m_pacq;
  longint m_pmean;
  int     m_blocks;
  int     m_locked;
  int     m_load;
  longint m_off;

  am_offset_ctrl #(
    .DATA_W(DATA_W), .LOG2_WIN(L), .SETTLE_BLOCKS(SETTLE), .STEP_SHIFT(SSHIFT)
  ) dut (
    .i_clk           (clk),
    .i_resetn        (rst_n),
    .iS_data         (iS_data),
    .i_valid         (i_valid),
    .i_enable        (i_enable),
    .i_freeze        (i_freeze),
    .i_manual        (i_manual),
    .iS_manual_offset(iS_manual_offset),
    .oS_offset       (oS_offset),
    .o_offset_load   (o_offset_load),
    .o_locked        (o_locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE; m_q.delete(); m_pend = 0; m_pacq = 0; m_pmean = 0;
    m_blocks = 0; m_locked = 0; m_load = 0; m_off = 0;
  endtask

  // One clock edge of the reference, from the inputs present at that edge.
  task automatic model_step();
    int     was_locked;
    longint s;
    was_locked = m_locked;
    if (!i_enable) begin
      m_phase = PH_IDLE; m_q.delete(); m_blocks = 0; m_locked = 0;
      m_pend = 0; m_load = 0;
    end else if (i_manual) begin
      m_off  = longint'($signed(iS_manual_offset));
      m_load = 1; m_q.delete(); m_pend = 0;
      m_phase = (m_phase == PH_IDLE) ? PH_RUN : PH_HOLD;
    end else begin
      m_load = 0;
      if (m_pend != 0) begin
        m_load = 1;
        if (m_pacq != 0) begin
          m_off = m_pmean;
          m_blocks++;
          if (m_blocks == SETTLE) m_locked = 1;
        end else begin
          m_off = m_off + fdiv(m_pmean - m_off, GAIN);
        end
      end
      m_pend = 0;
      if (i_freeze) begin
        m_q.delete();
        m_phase = (m_phase == PH_IDLE) ? PH_RUN : PH_HOLD;
      end else if (m_phase != PH_RUN) begin
        m_phase = PH_RUN;
      end else if (i_valid) begin
        m_q.push_back(longint'($signed(iS_data)));
        if (m_q.size() == WIN) begin
          s = 0;
          foreach (m_q[i]) s += m_q[i];
          m_pmean = fdiv(s, WIN);
          m_pend  = 1;
          m_pacq  = (was_locked == 0);
          m_q.delete();
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("offset", longint'($signed(oS_offset)), m_off);
    chk("load", longint'(o_offset_load), longint'(m_load));
    chk("locked", longint'(o_locked), longint'(m_locked));
  endtask

  task automatic drive(input logic v, input int d);
    i_valid = v;
    iS_data = 16'(d);
    tick();
  endtask

  initial begin
    int s2_exp[3];
    int man_left;
    int frz_left;
    int bias;
    int v;
    s2_exp = '{125, 143, 157};

    rst_n = 1'b0; i_valid = 1'b0; iS_data = '0; i_enable = 1'b0;
    i_freeze = 1'b0; i_manual = 1'b0; iS_manual_offset = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_offset", longint'($signed(oS_offset)), 0);
    chk("rst_load", longint'(o_offset_load), 0);
    chk("rst_locked", longint'(o_locked), 0);
    rst_n = 1'b1;

    // Constant 100: acquire, then lock after the second block
    i_enable = 1'b1;
    drive(1'b0, 0);
    for (int i = 0; i < 16; i++) drive(1'b1, 100);
    chk("s1_no_load_at_k", longint'(o_offset_load), 0);
    drive(1'b1, 100);
    chk("s1_load", longint'(o_offset_load), 1);
    chk("s1_offset", longint'($signed(oS_offset)), 100);
    chk("s1_not_locked", longint'(o_locked), 0);
    for (int i = 0; i < 15; i++) drive(1'b1, 100);
    drive(1'b0, 0);
    chk("s1_locked", longint'(o_locked), 1);
    chk("s1_offset2", longint'($signed(oS_offset)), 100);

    // Step to 200 while tracking
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) drive(1'b1, 200);
      drive(1'b0, 0);
      chk("s2_load", longint'(o_offset_load), 1);
      chk("s2_offset", longint'($signed(oS_offset)), longint'(s2_exp[b]));
    end

    // Ramp 0..15 after a fresh enable
    i_enable = 1'b0;
    drive(1'b0, 0);
    chk("s3_idle_unlocked", longint'(o_locked), 0);
    chk("s3_idle_holds", longint'($signed(oS_offset)), 157);
    i_enable = 1'b1;
    drive(1'b0, 0);
    for (int i = 0; i < 16; i++) drive(1'b1, i);
    drive(1'b0, 0);
    chk("s3_load", longint'(o_offset_load), 1);
    chk("s3_offset", longint'($signed(oS_offset)), 7);

    // Alternating -1,-2 with 50% valid
    i_enable = 1'b0;
    drive(1'b0, 0);
    i_enable = 1'b1;
    drive(1'b0, 0);
    for (int i = 0; i < 32; i++) drive((i % 2) == 0, ((i % 4) == 0) ? -1 : -2);
    chk("s4_load", longint'(o_offset_load), 1);
    chk("s4_offset", longint'($signed(oS_offset)), -2);

    // Freeze discards the partial block; block count survives
    for (int i = 0; i < 8; i++) drive(1'b1, 50);
    i_freeze = 1'b1;
    for (int i = 0; i < 10; i++) drive(1'b1, 999);
    chk("s5_frozen_offset", longint'($signed(oS_offset)), -2);
    i_freeze = 1'b0;
    drive(1'b0, 0);
    for (int i = 0; i < 16; i++) drive(1'b1, 40);
    chk("s5_no_early_load", longint'(o_offset_load), 0);
    chk("s5_offset_held", longint'($signed(oS_offset)), -2);
    drive(1'b0, 0);
    chk("s5_load", longint'(o_offset_load), 1);
    chk("s5_offset", longint'($signed(oS_offset)), 40);
    chk("s5_locked", longint'(o_locked), 1);

    // Manual override mid-block, release, then resume tracking
    for (int i = 0; i < 5; i++) drive(1'b1, 80);
    i_manual = 1'b1;
    iS_manual_offset = 16'(-300);
    drive(1'b1, 80);
    chk("s6_man_offset", longint'($signed(oS_offset)), -300);
    chk("s6_man_load", longint'(o_offset_load), 1);
    chk("s6_man_locked", longint'(o_locked), 1);
    drive(1'b1, 80);
    chk("s6_man_load2", longint'(o_offset_load), 1);
    i_manual = 1'b0;
    drive(1'b0, 0);
    chk("s6_release_noload", longint'(o_offset_load), 0);
    for (int i = 0; i < 16; i++) drive(1'b1, 100);
    drive(1'b0, 0);
    chk("s6_track_offset", longint'($signed(oS_offset)), -200);

    // Asynchronous reset mid-block
    for (int i = 0; i < 7; i++) drive(1'b1, 100);
    #2 rst_n = 1'b0;
    #1 model_reset();
    chk("arst_offset", longint'($signed(oS_offset)), 0);
    chk("arst_load", longint'(o_offset_load), 0);
    chk("arst_locked", longint'(o_locked), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic around a slowly changing DC bias
    man_left = 0;
    frz_left = 0;
    bias = 0;
    for (int c = 0; c < 3000; c++) begin
      if ((c % 400) == 0) bias = int'($urandom_range(0, 40000)) - 20000;
      if (man_left > 0) man_left--;
      else if ($urandom_range(0, 99) == 0) man_left = int'($urandom_range(1, 4));
      if (frz_left > 0) frz_left--;
      else if ($urandom_range(0, 59) == 0) frz_left = int'($urandom_range(1, 20));
      i_enable = ($urandom_range(0, 399) != 0);
      i_manual = (man_left > 0);
      i_freeze = (frz_left > 0);
      iS_manual_offset = 16'($urandom);
      v = bias + int'($urandom_range(0, 511)) - 256;
      drive($urandom_range(0, 3) != 0, v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
